// File: rtl/rv32_csr_unit.sv
// Machine-mode CSR unit: CSRRW/RS/RC (+immediate forms), tohost mailbox and
// 64-bit mcycle/minstret counters, which exist only when CSR_COUNTERS_EN is defined.
module rv32_csr_unit #(
  parameter logic [11:0] TOHOST_ADDR  = 12'h51E,
  parameter logic [31:0] TOHOST_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_funct3,
  input  logic [4:0]  csr_rs1,
  input  logic [31:0] csr_rs1_data,
  input  logic        retire,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] tohost,
  output logic        tohost_wr
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  csr_op_e     op;
  logic [31:0] src;
  logic [31:0] old_value;
  logic [31:0] new_value;
  logic        mapped;
  logic        write_req;
  logic        illegal_access;
  logic        accept;
  logic [31:0] tohost_reg;
  logic        tohost_wr_reg;
  logic [63:0] cycle_count;
  logic [63:0] instret_count;

  assign op  = csr_op_e'(csr_funct3[1:0]);
  assign src = csr_funct3[2] ? {27'b0, csr_rs1} : csr_rs1_data;

  // Set/clear with rs1/zimm == 0 is a pure read, so it may target read-only CSRs.
  assign write_req = (op == OP_RW) || ((op != OP_NONE) && (csr_rs1 != 5'd0));

  always_comb begin
    mapped    = 1'b1;
    old_value = '0;
    if (csr_addr == TOHOST_ADDR) begin
      old_value = tohost_reg;
    end else begin
      case (csr_addr)
        12'hB00, 12'hC00: old_value = cycle_count[31:0];
        12'hB80, 12'hC80: old_value = cycle_count[63:32];
        12'hB02, 12'hC02: old_value = instret_count[31:0];
        12'hB82, 12'hC82: old_value = instret_count[63:32];
        default:          mapped    = 1'b0;
      endcase
    end
  end

  always_comb begin
    new_value = old_value;
    case (op)
      OP_RW:   new_value = src;
      OP_RS:   new_value = old_value | src;
      OP_RC:   new_value = old_value & ~src;
      default: new_value = old_value;
    endcase
  end

  assign illegal_access = !mapped || (op == OP_NONE) ||
                          (write_req && (csr_addr[11:10] == 2'b11));
  assign csr_illegal    = csr_en && illegal_access;
  assign csr_rdata      = (csr_en && mapped) ? old_value : '0;
  assign accept         = csr_en && !illegal_access && write_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      tohost_reg    <= TOHOST_RESET;
      tohost_wr_reg <= 1'b0;
    end else begin
      tohost_wr_reg <= accept && (csr_addr == TOHOST_ADDR);
      if (accept && (csr_addr == TOHOST_ADDR)) begin
        tohost_reg <= new_value;
      end
    end
  end

  assign tohost    = tohost_reg;
  assign tohost_wr = tohost_wr_reg;

`ifdef CSR_COUNTERS_EN
  // Index 0 is mcycle (always counting), index 1 is minstret (counts retires).
  logic [63:0] count [2];
  logic [1:0]  count_inc;
  logic [1:0]  write_lo;
  logic [1:0]  write_hi;

  assign count_inc = {retire, 1'b1};
  assign write_lo  = {accept && (csr_addr == 12'hB02), accept && (csr_addr == 12'hB00)};
  assign write_hi  = {accept && (csr_addr == 12'hB82), accept && (csr_addr == 12'hB80)};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_counter
      logic [63:0] count_reg;
      logic [31:0] low_bumped;

      // Carry out of the low half is dropped when the high half is written.
      assign low_bumped = count_reg[31:0] + {31'b0, count_inc[gi]};

      always_ff @(posedge clk) begin
        if (rst) begin
          count_reg <= '0;
        end else if (write_lo[gi]) begin
          count_reg <= {count_reg[63:32], new_value};
        end else if (write_hi[gi]) begin
          count_reg <= {new_value, low_bumped};
        end else begin
          count_reg <= count_reg + {63'b0, count_inc[gi]};
        end
      end

      assign count[gi] = count_reg;
    end
  endgenerate

  assign cycle_count   = count[0];
  assign instret_count = count[1];
`else
  logic counters_unused;

  assign cycle_count     = '0;
  assign instret_count   = '0;
  assign counters_unused = retire;
`endif

endmodule

// File: tb/tb_rv32_csr_unit.sv
// Self-checking bench for rv32_csr_unit: directed scenarios plus randomized
// traffic against a behavioural CSR model (counter model active with CSR_COUNTERS_EN).
module tb_rv32_csr_unit;

`ifdef CSR_COUNTERS_EN
  localparam bit COUNTERS = 1'b1;
`else
  localparam bit COUNTERS = 1'b0;
`endif
  localparam logic [11:0] TH = 12'h51E;

  logic        clk;
  logic        rst;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [2:0]  csr_funct3;
  logic [4:0]  csr_rs1;
  logic [31:0] csr_rs1_data;
  logic        retire;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] tohost;
  logic        tohost_wr;

  rv32_csr_unit #(.TOHOST_ADDR(TH), .TOHOST_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .csr_addr(csr_addr),
    .csr_funct3(csr_funct3), .csr_rs1(csr_rs1), .csr_rs1_data(csr_rs1_data),
    .retire(retire), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .tohost(tohost), .tohost_wr(tohost_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Behavioural model state
  logic [31:0] m_tohost;
  logic [63:0] m_mcycle;
  logic [63:0] m_minstret;
  logic        m_wr;

  // Per-transaction observations and model expectations
  logic [31:0] obs_rdata, exp_rdata, obs_tohost;
  logic        obs_illegal, exp_illegal, obs_tohost_wr;

  function automatic bit model_mapped(input logic [11:0] a);
    case (a)
      TH, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == TH) return m_tohost;
    if (!COUNTERS) return 32'h0;
    case (a)
      12'hB00, 12'hC00: return m_mcycle[31:0];
      12'hB80, 12'hC80: return m_mcycle[63:32];
      12'hB02, 12'hC02: return m_minstret[31:0];
      12'hB82, 12'hC82: return m_minstret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  // One clock cycle: drive inputs, predict, sample combinational outputs on the
  // falling edge, advance the model on the rising edge, sample registers after it.
  task automatic step(input logic r, input logic en, input logic [11:0] a,
                      input logic [2:0] f3, input logic [4:0] r1,
                      input logic [31:0] d, input logic ret);
    logic [31:0] src, old, nv;
    logic        writes, ill;
    logic [63:0] nxt_c, nxt_i;
    rst = r; csr_en = en; csr_addr = a; csr_funct3 = f3;
    csr_rs1 = r1; csr_rs1_data = d; retire = ret;
    src    = f3[2] ? {27'b0, r1} : d;
    old    = model_read(a);
    writes = (f3[1:0] == 2'b01) || ((f3[1:0] != 2'b00) && (r1 != 5'd0));
    ill    = !model_mapped(a) || (f3[1:0] == 2'b00) || (writes && (a[11:10] == 2'b11));
    exp_illegal = en && ill;
    exp_rdata   = (en && model_mapped(a)) ? old : 32'h0;
    case (f3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    @(negedge clk);
    obs_rdata   = csr_rdata;
    obs_illegal = csr_illegal;
    @(posedge clk);
    if (r) begin
      m_tohost = 32'h0; m_mcycle = 64'h0; m_minstret = 64'h0; m_wr = 1'b0;
    end else begin
      nxt_c = m_mcycle + 64'd1;
      nxt_i = m_minstret + {63'b0, ret};
      m_wr  = 1'b0;
      if (en && !ill && writes) begin
        case (a)
          TH:      begin m_tohost = nv; m_wr = 1'b1; end
          12'hB00: nxt_c = {m_mcycle[63:32], nv};
          12'hB80: nxt_c = {nv, m_mcycle[31:0] + 32'd1};
          12'hB02: nxt_i = {m_minstret[63:32], nv};
          12'hB82: nxt_i = {nv, m_minstret[31:0] + {31'b0, ret}};
          default: ;
        endcase
      end
      m_mcycle = nxt_c;
      m_minstret = nxt_i;
    end
    #1;
    obs_tohost    = tohost;
    obs_tohost_wr = tohost_wr;
    txn++;
    $display("txn %0d rst=%0b en=%0b addr=%h f3=%0d rs1=%0d data=%h ret=%0b -> rdata=%h ill=%0b tohost=%h wr=%0b",
             txn, r, en, a, f3, r1, d, ret, obs_rdata, obs_illegal, obs_tohost, obs_tohost_wr);
  endtask

  task automatic idle(input logic ret);
    step(1'b0, 1'b0, 12'h000, 3'b000, 5'd0, 32'h0, ret);
  endtask

  task automatic test_reset();
    int n;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 12'h0, 3'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if (obs_tohost !== 32'h0) begin errors++; $display("FAIL reset_tohost got %h want %h", obs_tohost, 32'h0); end
    checks++;
    if (obs_tohost_wr !== 1'b0) begin errors++; $display("FAIL reset_tohost_wr got %0b want 0", obs_tohost_wr); end
    n = int'($urandom_range(20, 3));
    for (int i = 0; i < n; i++) idle(1'b0);
    step(1'b0, 1'b1, 12'hB00, 3'b010, 5'd0, 32'h0, 1'b0);
    checks++;
    if (obs_rdata !== (COUNTERS ? 32'(n) : 32'h0)) begin
      errors++; $display("FAIL reset_mcycle got %0d want %0d", obs_rdata, COUNTERS ? n : 0);
    end
    checks++;
    if (obs_illegal !== 1'b0) begin errors++; $display("FAIL reset_mcycle_illegal got %0b want 0", obs_illegal); end
  endtask

  task automatic test_tohost_rwi();
    step(1'b0, 1'b1, TH, 3'b101, 5'd1, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (obs_rdata !== 32'h0) begin errors++; $display("FAIL rwi_rdata got %h want 0", obs_rdata); end
    checks++;
    if (obs_tohost !== 32'h1) begin errors++; $display("FAIL rwi_tohost got %h want 1", obs_tohost); end
    checks++;
    if (obs_tohost_wr !== 1'b1) begin errors++; $display("FAIL rwi_pulse got %0b want 1", obs_tohost_wr); end
    idle(1'b0);
    checks++;
    if (obs_tohost_wr !== 1'b0) begin errors++; $display("FAIL rwi_pulse_end got %0b want 0", obs_tohost_wr); end
  endtask

  task automatic test_rw_rc();
    step(1'b0, 1'b1, TH, 3'b001, 5'd7, 32'hFFFF_00F0, 1'b0);
    step(1'b0, 1'b1, TH, 3'b011, 5'd9, 32'h0000_00F0, 1'b0);
    checks++;
    if (obs_rdata !== 32'hFFFF_00F0) begin errors++; $display("FAIL rc_rdata got %h want %h", obs_rdata, 32'hFFFF_00F0); end
    checks++;
    if (obs_tohost !== 32'hFFFF_0000) begin errors++; $display("FAIL rc_tohost got %h want %h", obs_tohost, 32'hFFFF_0000); end
    // Set with rs1=0 is a read: no write, no pulse
    step(1'b0, 1'b1, TH, 3'b010, 5'd0, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (obs_tohost_wr !== 1'b0 || obs_tohost !== 32'hFFFF_0000) begin
      errors++; $display("FAIL rs0_nowrite got %h/%0b want %h/0", obs_tohost, obs_tohost_wr, 32'hFFFF_0000);
    end
  endtask

  task automatic test_readonly();
    step(1'b0, 1'b1, 12'hC00, 3'b010, 5'd0, 32'h0, 1'b0);
    checks++;
    if (obs_rdata !== exp_rdata || obs_illegal !== 1'b0) begin
      errors++; $display("FAIL ro_read got %h/%0b want %h/0", obs_rdata, obs_illegal, exp_rdata);
    end
    step(1'b0, 1'b1, 12'hC00, 3'b001, 5'd3, 32'h1234_5678, 1'b0);
    checks++;
    if (obs_illegal !== 1'b1) begin errors++; $display("FAIL ro_write_illegal got %0b want 1", obs_illegal); end
    step(1'b0, 1'b1, 12'hB00, 3'b010, 5'd0, 32'h0, 1'b0);
    checks++;
    if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL ro_mcycle_kept got %h want %h", obs_rdata, exp_rdata); end
    step(1'b0, 1'b1, 12'h7FF, 3'b001, 5'd3, 32'h1, 1'b0);
    checks++;
    if (obs_illegal !== 1'b1 || obs_rdata !== 32'h0) begin
      errors++; $display("FAIL unmapped got %h/%0b want 0/1", obs_rdata, obs_illegal);
    end
    step(1'b0, 1'b1, TH, 3'b100, 5'd3, 32'h1, 1'b0);
    checks++;
    if (obs_illegal !== 1'b1 || obs_tohost_wr !== 1'b0) begin
      errors++; $display("FAIL bad_funct3 got ill=%0b wr=%0b want 1/0", obs_illegal, obs_tohost_wr);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 12'hB80, 3'b001, 5'd1, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (obs_illegal !== 1'b0) begin errors++; $display("FAIL wrap_hi_illegal got %0b want 0", obs_illegal); end
    step(1'b0, 1'b1, 12'hB00, 3'b001, 5'd1, 32'hFFFF_FFFF, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b1, 12'hB00, 3'b010, 5'd0, 32'h0, 1'b0);
    checks++;
    if (obs_rdata !== 32'h0) begin errors++; $display("FAIL wrap_lo got %h want 0", obs_rdata); end
    step(1'b0, 1'b1, 12'hB80, 3'b010, 5'd0, 32'h0, 1'b0);
    checks++;
    if (obs_rdata !== 32'h0) begin errors++; $display("FAIL wrap_hi got %h want 0", obs_rdata); end
  endtask

  task automatic test_minstret();
    step(1'b0, 1'b1, 12'hB02, 3'b001, 5'd2, 32'd5, 1'b1);
    step(1'b0, 1'b1, 12'hB02, 3'b010, 5'd0, 32'h0, 1'b0);
    checks++;
    if (obs_rdata !== (COUNTERS ? 32'd5 : 32'd0)) begin errors++; $display("FAIL minstret_write got %0d want 5", obs_rdata); end
    idle(1'b1);
    step(1'b0, 1'b1, 12'hC02, 3'b010, 5'd0, 32'h0, 1'b0);
    checks++;
    if (obs_rdata !== (COUNTERS ? 32'd6 : 32'd0)) begin errors++; $display("FAIL minstret_retire got %0d want 6", obs_rdata); end
  endtask

  task automatic test_reset_priority();
    step(1'b0, 1'b1, TH, 3'b001, 5'd1, 32'h0000_1234, 1'b0);
    step(1'b1, 1'b1, TH, 3'b001, 5'd1, 32'h0000_ABCD, 1'b1);
    checks++;
    if (obs_tohost !== 32'h0 || obs_tohost_wr !== 1'b0) begin
      errors++; $display("FAIL rst_priority got %h/%0b want 0/0", obs_tohost, obs_tohost_wr);
    end
    idle(1'b0);
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, TH, 3'b001, 5'd4, 32'hA5A5_0000, 1'b0);
    step(1'b0, 1'b1, TH, 3'b110, 5'd5, 32'h0, 1'b0);
    checks++;
    if (obs_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL b2b_rdata got %h want %h", obs_rdata, 32'hA5A5_0000); end
    checks++;
    if (obs_tohost !== 32'hA5A5_0005 || obs_tohost_wr !== 1'b1) begin
      errors++; $display("FAIL b2b_tohost got %h/%0b want %h/1", obs_tohost, obs_tohost_wr, 32'hA5A5_0005);
    end
  endtask

  task automatic test_random();
    logic [11:0] addrs [10];
    logic [11:0] a;
    logic [4:0]  r1;
    addrs = '{TH, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7FF};
    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(9, 0) == 0) ? 12'($urandom) : addrs[$urandom_range(9, 0)];
      r1 = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom);
      step(1'b0, 1'($urandom_range(3, 0) != 0), a, 3'($urandom), r1, $urandom, 1'($urandom));
      checks++;
      if (obs_illegal !== exp_illegal) begin errors++; $display("FAIL rnd_illegal txn %0d got %0b want %0b", txn, obs_illegal, exp_illegal); end
      if (csr_funct3[1:0] != 2'b00 || !csr_en) begin
        checks++;
        if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata txn %0d got %h want %h", txn, obs_rdata, exp_rdata); end
      end
      checks++;
      if (obs_tohost !== m_tohost || obs_tohost_wr !== m_wr) begin
        errors++; $display("FAIL rnd_tohost txn %0d got %h/%0b want %h/%0b", txn, obs_tohost, obs_tohost_wr, m_tohost, m_wr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; csr_en = 1'b0; csr_addr = '0; csr_funct3 = '0;
    csr_rs1 = '0; csr_rs1_data = '0; retire = 1'b0;
    m_tohost = '0; m_mcycle = '0; m_minstret = '0; m_wr = 1'b0;
    test_reset();
    test_tohost_rwi();
    test_rw_rc();
    test_readonly();
    test_wrap();
    test_minstret();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
